ex_stage: RTL and testbench

- Execute stage of the 3-stage RV32I pipeline, directly downstream of the ALU decoder.
- Consumes the decoder's 4-bit ALUop together with decoded operands, and resolves RAW hazards by forwarding.
- Performs the ALU operation and captures the result in the EX/WB pipeline register.
- Supports stall (hold) and flush (kill) from the hazard/branch control.

---
 rtl/ex_stage.sv | 162 ++++++++++++++++
 tb/tb_ex_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 3-stage RV32I pipeline.
//
// Takes the decoded ALUop plus operands and resolves RAW hazards by forwarding:
// the EX/WB register has first priority and the writeback-stage load path second.
// It runs the ALU and captures the result in the EX/WB register. Stall holds that
// register, and flush kills the instruction being captured.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid                   EX-stage instruction valid
//   stall, flush               hold / kill from hazard and branch control
//   ALUop[3:0]                 ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6
//                              SLL=7 SRA=8 SRL=9 COPY_B=10, others give 0
//   rs1_addr, rs2_addr         source register indices
//   rs1_data, rs2_data         register-file read data
//   imm, pc                    sign-extended immediate, instruction PC
//   a_sel_pc, b_sel_imm        operand A = pc, operand B = imm
//   rd_addr, reg_we            destination index and its write request
//   wb_we, wb_rd, wb_data      writeback-stage write (forwarding source)
//   out_valid, out_we, out_rd  EX/WB valid, write enable, destination
//   out_result                 registered ALU result
//   out_store_data             registered forwarded rs2 (store data)
module ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [3:0]         ALUop,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    pc,
  input  logic               a_sel_pc,
  input  logic               b_sel_imm,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_we,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               out_valid,
  output logic               out_we,
  output logic [RADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_store_data
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_COPY = 4'd10;

  logic               valid_r;
  logic               we_r;
  logic [RADDR_W-1:0] rd_r;
  logic [XLEN-1:0]    result_r;
  logic [XLEN-1:0]    store_r;

  logic [XLEN-1:0]    fwd_rs1_s;
  logic [XLEN-1:0]    fwd_rs2_s;
  logic [XLEN-1:0]    op_a_s;
  logic [XLEN-1:0]    op_b_s;
  logic [XLEN-1:0]    alu_s;

  // ALU result; undefined opcodes give zero so a bad decode cannot leak data.
  function automatic logic [XLEN-1:0] alu_f(
    input logic [3:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    r = {XLEN{1'b0}};
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL:  r = a << b[SHW-1:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_SRL:  r = a >> b[SHW-1:0];
      OP_COPY: r = b;
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // Forwarding muxes: the EX/WB register outranks the writeback stage because it
  // is younger; index 0 is hardwired zero and never forwards. The EX/WB source
  // stays live during stall so the held instruction keeps feeding dependents.
  always_comb begin
    fwd_rs1_s = rs1_data;
    fwd_rs2_s = rs2_data;
    if (valid_r && we_r && (rd_r == rs1_addr) && (rs1_addr != {RADDR_W{1'b0}})) begin
      fwd_rs1_s = result_r;
    end else if (wb_we && (wb_rd == rs1_addr) && (rs1_addr != {RADDR_W{1'b0}})) begin
      fwd_rs1_s = wb_data;
    end else begin
      fwd_rs1_s = rs1_data;
    end
    if (valid_r && we_r && (rd_r == rs2_addr) && (rs2_addr != {RADDR_W{1'b0}})) begin
      fwd_rs2_s = result_r;
    end else if (wb_we && (wb_rd == rs2_addr) && (rs2_addr != {RADDR_W{1'b0}})) begin
      fwd_rs2_s = wb_data;
    end else begin
      fwd_rs2_s = rs2_data;
    end
  end

  // Operand selection and ALU evaluation.
  always_comb begin
    op_a_s = a_sel_pc  ? pc  : fwd_rs1_s;
    op_b_s = b_sel_imm ? imm : fwd_rs2_s;
    alu_s  = alu_f(ALUop, op_a_s, op_b_s);
  end

  // EX/WB register: reset > flush > stall > capture. Flush only clears the
  // control bits; the data fields hold because nothing consumes them while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= 1'b0;
      we_r     <= 1'b0;
      rd_r     <= {RADDR_W{1'b0}};
      result_r <= {XLEN{1'b0}};
      store_r  <= {XLEN{1'b0}};
    end else if (flush) begin
      valid_r  <= 1'b0;
      we_r     <= 1'b0;
    end else if (stall) begin
      valid_r  <= valid_r;
    end else begin
      valid_r  <= in_valid;
      we_r     <= in_valid & reg_we & (rd_addr != {RADDR_W{1'b0}});
      rd_r     <= rd_addr;
      result_r <= alu_s;
      store_r  <= fwd_rs2_s;
    end
  end

  assign out_valid      = valid_r;
  assign out_we         = we_r;
  assign out_rd         = rd_r;
  assign out_result     = result_r;
  assign out_store_data = store_r;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Directed scenarios check fixed
// values, and a randomized run is checked against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [3:0]  alu_op;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_rd;
  logic [31:0] rs1_data, rs2_data, imm, pc, wb_data;
  logic        a_sel_pc, b_sel_imm, reg_we, wb_we;
  logic        out_valid, out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_result, out_store_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the EX/WB register contents.
  logic        m_valid = 1'b0, m_we = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_result = 32'd0, m_store = 32'd0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ALUop(alu_op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .a_sel_pc(a_sel_pc), .b_sel_imm(b_sel_imm), .rd_addr(rd_addr), .reg_we(reg_we),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd),
    .out_result(out_result), .out_store_data(out_store_data)
  );

  // ALU reference written with plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, q;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    sh = int'(b[4:0]);
    p = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd7:  return 32'(ua * p);
      4'd8:  begin
        if (sa >= 0) q = sa / p;
        else q = -(((-sa) + p - 1) / p);
        return 32'(q);
      end
      4'd9:  return 32'(ua / p);
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] data);
    if (addr == 5'd0) return data;
    if (m_valid && m_we && m_rd == addr) return m_result;
    if (wb_we && wb_rd == addr) return wb_data;
    return data;
  endfunction

  task automatic idle();
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; alu_op = 4'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0; wb_rd = 5'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; pc = 32'd0; wb_data = 32'd0;
    a_sel_pc = 1'b0; b_sel_imm = 1'b0; reg_we = 1'b0; wb_we = 1'b0;
  endtask

  // One clock: evaluate the model on current inputs, clock, then sample 1ns later.
  task automatic step();
    logic [31:0] f2, a, b, r;
    f2 = ref_fwd(rs2_addr, rs2_data);
    a  = a_sel_pc ? pc : ref_fwd(rs1_addr, rs1_data);
    b  = b_sel_imm ? imm : f2;
    r  = ref_alu(alu_op, a, b);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_result = 32'd0; m_store = 32'd0;
    end else if (flush) begin
      m_valid = 1'b0; m_we = 1'b0;
    end else if (!stall) begin
      m_valid = in_valid; m_we = in_valid && reg_we && (rd_addr != 5'd0);
      m_rd = rd_addr; m_result = r; m_store = f2;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; in_valid = 1'b1; reg_we = 1'b1; rd_addr = 5'd9;
    step(); step();
    n_cmp++; if ({out_valid, out_we, out_rd, out_result, out_store_data} !== 71'd0) begin
      n_bad++; $display("FAIL reset_state: got v=%b we=%b rd=%0d res=%h st=%h want all 0",
                        out_valid, out_we, out_rd, out_result, out_store_data); end
    idle();
  endtask

  task automatic test_basic_ops();
    idle(); in_valid = 1'b1; rd_addr = 5'd10; rs1_addr = 5'd1; rs2_addr = 5'd2;
    rs1_data = 32'h0000_0007; rs2_data = 32'hFFFF_FFFE; alu_op = 4'd1;
    n_cmp++; if (out_result !== 32'd0) begin n_bad++;
      $display("FAIL sub_not_early: got %h want %h", out_result, 32'd0); end
    step();
    n_cmp++; if (out_result !== 32'h0000_0009 || out_valid !== 1'b1) begin n_bad++;
      $display("FAIL sub_result: got %h v=%b want %h v=1", out_result, out_valid, 32'h9); end
    alu_op = 4'd5; step();
    n_cmp++; if (out_result !== 32'd0) begin n_bad++;
      $display("FAIL slt_result: got %h want %h", out_result, 32'd0); end
    alu_op = 4'd6; step();
    n_cmp++; if (out_result !== 32'd1) begin n_bad++;
      $display("FAIL sltu_result: got %h want %h", out_result, 32'd1); end
    rs1_data = 32'h8000_0000; b_sel_imm = 1'b1; imm = 32'h0000_001F; alu_op = 4'd8; step();
    n_cmp++; if (out_result !== 32'hFFFF_FFFF) begin n_bad++;
      $display("FAIL sra_result: got %h want %h", out_result, 32'hFFFF_FFFF); end
    alu_op = 4'd9; step();
    n_cmp++; if (out_result !== 32'h0000_0001) begin n_bad++;
      $display("FAIL srl_result: got %h want %h", out_result, 32'h1); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle(); in_valid = 1'b1; reg_we = 1'b1; alu_op = 4'd0;
    rd_addr = 5'd5; b_sel_imm = 1'b1; imm = 32'd5; step();
    rd_addr = 5'd6; b_sel_imm = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5; step();
    n_cmp++; if (out_result !== 32'd10 || out_store_data !== 32'd5) begin n_bad++;
      $display("FAIL b2b_forward: got res=%h st=%h want res=%h st=%h", out_result, out_store_data, 32'd10, 32'd5); end
    idle();
  endtask

  task automatic test_double_hazard();
    idle(); in_valid = 1'b1; reg_we = 1'b1; alu_op = 4'd10; b_sel_imm = 1'b1;
    imm = 32'h11; rd_addr = 5'd3; step();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h22; alu_op = 4'd0; imm = 32'd0;
    rs1_addr = 5'd3; rs1_data = 32'h99; rs2_addr = 5'd3; rd_addr = 5'd4; step();
    n_cmp++; if (out_result !== 32'h11 || out_store_data !== 32'h11) begin n_bad++;
      $display("FAIL exwb_priority: got res=%h st=%h want %h", out_result, out_store_data, 32'h11); end
    wb_we = 1'b0; alu_op = 4'd10; imm = 32'h11; rd_addr = 5'd0; step();
    wb_we = 1'b1; wb_rd = 5'd0; alu_op = 4'd0; imm = 32'd0;
    rs1_addr = 5'd0; rs1_data = 32'h44; rs2_addr = 5'd0; rs2_data = 32'h55; step();
    n_cmp++; if (out_result !== 32'h44 || out_store_data !== 32'h55) begin n_bad++;
      $display("FAIL x0_no_forward: got res=%h st=%h want %h %h", out_result, out_store_data, 32'h44, 32'h55); end
    idle();
  endtask

  task automatic test_stall_flush();
    idle(); in_valid = 1'b1; reg_we = 1'b1; alu_op = 4'd0; rd_addr = 5'd7;
    rs1_data = 32'h10; b_sel_imm = 1'b1; imm = 32'h20; step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_op = 4'($urandom_range(0, 10)); rs1_data = $urandom; imm = $urandom; rd_addr = 5'd8;
      step();
      n_cmp++; if (out_result !== 32'h30 || out_valid !== 1'b1 || out_rd !== 5'd7) begin n_bad++;
        $display("FAIL stall_hold: cycle %0d got res=%h v=%b rd=%0d want %h 1 7", i, out_result, out_valid, out_rd, 32'h30); end
    end
    stall = 1'b0; alu_op = 4'd0; rs1_addr = 5'd7; rs1_data = 32'd0; imm = 32'd1; rd_addr = 5'd9; step();
    n_cmp++; if (out_result !== 32'h31) begin n_bad++;
      $display("FAIL fwd_after_stall: got %h want %h", out_result, 32'h31); end
    stall = 1'b1; flush = 1'b1; imm = 32'h77; step();
    n_cmp++; if (out_valid !== 1'b0 || out_we !== 1'b0 || out_result !== 32'h31) begin n_bad++;
      $display("FAIL stall_flush: got v=%b we=%b res=%h want 0 0 %h", out_valid, out_we, out_result, 32'h31); end
    idle();
  endtask

  task automatic test_x0_write();
    idle(); in_valid = 1'b1; reg_we = 1'b1; rd_addr = 5'd0; alu_op = 4'd0; step();
    n_cmp++; if (out_we !== 1'b0 || out_valid !== 1'b1) begin n_bad++;
      $display("FAIL x0_we: got we=%b v=%b want we=0 v=1", out_we, out_valid); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); in_valid = 1'b1; reg_we = 1'b1; rd_addr = 5'd12; b_sel_imm = 1'b1;
    imm = 32'hABCD; alu_op = 4'd10; step();
    stall = 1'b1; reset = 1'b1; step();
    n_cmp++; if ({out_valid, out_we, out_rd, out_result, out_store_data} !== 71'd0) begin n_bad++;
      $display("FAIL reset_mid_stall: got v=%b we=%b rd=%0d res=%h want all 0", out_valid, out_we, out_rd, out_result); end
    stall = 1'b0; reset = 1'b0; alu_op = 4'hF; imm = 32'h1234; step();
    n_cmp++; if (out_result !== 32'd0 || out_valid !== 1'b1) begin n_bad++;
      $display("FAIL undef_op: got res=%h v=%b want 0 v=1", out_result, out_valid); end
    idle();
  endtask

  task automatic test_random();
    idle(); reset = 1'b1; step();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0); stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0); in_valid = ($urandom_range(0, 5) != 0);
      alu_op = 4'($urandom_range(0, 15)); reg_we = ($urandom_range(0, 3) != 0);
      rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
      rd_addr = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      wb_we = $urandom_range(0, 1) == 1; a_sel_pc = ($urandom_range(0, 4) == 0);
      b_sel_imm = $urandom_range(0, 1) == 1;
      rs1_data = $urandom; rs2_data = $urandom; wb_data = $urandom; pc = $urandom;
      imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      step();
      n_cmp++; if (out_valid !== m_valid || out_we !== m_we || out_rd !== m_rd ||
                   out_result !== m_result || out_store_data !== m_store) begin n_bad++;
        $display("FAIL random_%0d: got v=%b we=%b rd=%0d res=%h st=%h want v=%b we=%b rd=%0d res=%h st=%h",
                 i, out_valid, out_we, out_rd, out_result, out_store_data,
                 m_valid, m_we, m_rd, m_result, m_store); end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_double_hazard();
    test_stall_flush();
    test_x0_write();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
